// File: rtl/sev_seg_pkg.sv
// Shared glyph encoding, converter sizing and controller state type for the
// seven-segment scanner.
package sev_seg_pkg;

  // Segment order is {a,b,c,d,e,f,g}; a 0 lights the segment.
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;
  localparam logic [6:0] GLYPH_DASH  = 7'b111_1110;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Decimal digits needed for value_w bits: floor(value_w * log10(2)) + 1.
  function automatic int bcd_n(input int value_w);
    return (value_w * 30103) / 100000 + 1;
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] nibble);
    logic [6:0] g;
    case (nibble)
      4'h0:    g = 7'b000_0001;
      4'h1:    g = 7'b100_1111;
      4'h2:    g = 7'b001_0010;
      4'h3:    g = 7'b000_0110;
      4'h4:    g = 7'b100_1100;
      4'h5:    g = 7'b010_0100;
      4'h6:    g = 7'b010_0000;
      4'h7:    g = 7'b000_1111;
      4'h8:    g = 7'b000_0000;
      4'h9:    g = 7'b000_0100;
      4'hA:    g = 7'b000_1000;
      4'hB:    g = 7'b110_0000;
      4'hC:    g = 7'b011_0001;
      4'hD:    g = 7'b100_0010;
      4'hE:    g = 7'b011_0000;
      4'hF:    g = 7'b011_1000;
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/sev_seg_scanner_bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift iteration per cycle, VALUE_W
// iterations after start; done marks the cycle of the final iteration.
module bin2bcd_seq
  import sev_seg_pkg::*;
#(
  parameter int VALUE_W = 32
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             start,
  input  logic [VALUE_W-1:0]               value,
  output logic [4*bcd_n(VALUE_W)-1:0]      bcd,
  output logic                             done
);

  localparam int BCD_N = bcd_n(VALUE_W);
  localparam int BCD_W = 4 * BCD_N;
  localparam int CNT_W = $clog2(VALUE_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(VALUE_W - 1);

  logic [VALUE_W-1:0]       bin_r;
  logic [BCD_W-1:0]         bcd_r;
  logic [BCD_W-1:0]         adj_s;
  logic [BCD_W+VALUE_W-1:0] shifted_s;
  logic [CNT_W-1:0]         cnt_r;
  logic                     run_r;

  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < BCD_N; i++) begin
      if (b[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = b[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Correct every BCD nibble, then shift the whole BCD:binary pair left by one.
  always_comb begin
    adj_s     = add3(bcd_r);
    shifted_s = {adj_s, bin_r} << 1;
  end

  // Conversion datapath and iteration counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bin_r <= '0;
      bcd_r <= '0;
      cnt_r <= '0;
      run_r <= 1'b0;
    end else if (start) begin
      bin_r <= value;
      bcd_r <= '0;
      cnt_r <= '0;
      run_r <= 1'b1;
    end else if (run_r) begin
      {bcd_r, bin_r} <= shifted_s;
      cnt_r          <= cnt_r + CNT_W'(1);
      run_r          <= (cnt_r != LAST);
    end
  end

  assign bcd  = bcd_r;
  assign done = run_r && (cnt_r == LAST);

endmodule

// File: rtl/sev_seg_scanner.sv
// Multiplexed common-anode seven-segment driver: converts a loaded value to
// decimal or hex glyphs, then scans them out on active-low anodes/cathodes.
module sev_seg_scanner
  import sev_seg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int VALUE_W     = 32,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_LZ    = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [VALUE_W-1:0] value,
  input  logic               load,
  input  logic               hex_mode,
  input  logic [DIGITS-1:0]  dp_mask,
  output logic               busy,
  output logic               CA,
  output logic               CB,
  output logic               CC,
  output logic               CD,
  output logic               CE,
  output logic               CF,
  output logic               CG,
  output logic               DP,
  output logic [DIGITS-1:0]  AN
);

  localparam int BCD_N  = bcd_n(VALUE_W);
  localparam int BCD_W  = 4 * BCD_N;
  localparam int EXT_W  = 4 * DIGITS + ((VALUE_W > BCD_W) ? VALUE_W : BCD_W);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  state_t             state_r;
  state_t             state_s;
  logic               busy_r;
  logic               accept_s;
  logic               conv_start_s;
  logic               conv_done_s;
  logic [BCD_W-1:0]   bcd_s;

  logic [VALUE_W-1:0] val_r;
  logic               hex_r;
  logic [DIGITS-1:0]  dpm_r;

  logic [EXT_W-1:0]   val_ext_s;
  logic [EXT_W-1:0]   bcd_ext_s;
  logic               ovf_s;
  logic               lead_s;
  logic [3:0]         nib_s;
  logic [6:0]         glyph_s [DIGITS];

  logic [6:0]         disp_glyph_r [DIGITS];
  logic [DIGITS-1:0]  disp_dp_r;

  logic [CNT_W-1:0]   cnt_r;
  logic [IDX_W-1:0]   idx_r;
  logic [6:0]         seg_r;
  logic               dp_pin_r;
  logic [DIGITS-1:0]  an_r;

  assign accept_s     = (state_r == IDLE) && load;
  assign conv_start_s = accept_s && !hex_mode;

  bin2bcd_seq #(
    .VALUE_W (VALUE_W)
  ) u_bin2bcd (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (conv_start_s),
    .value   (value),
    .bcd     (bcd_s),
    .done    (conv_done_s)
  );

  // Controller state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; loads outside IDLE are simply not looked at.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (load) begin
          state_s = hex_mode ? COMMIT : SHIFT;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (conv_done_s) begin
          state_s = COMMIT;
        end else begin
          state_s = SHIFT;
        end
      end
      COMMIT:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Registered busy flag, tracking whether the next state is a working state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= (state_s != IDLE);
    end
  end

  // Capture the request on an accepted load.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      val_r <= '0;
      hex_r <= 1'b0;
      dpm_r <= '0;
    end else if (accept_s) begin
      val_r <= value;
      hex_r <= hex_mode;
      dpm_r <= dp_mask;
    end
  end

  assign val_ext_s = EXT_W'(val_r);
  assign bcd_ext_s = EXT_W'(bcd_s);

  // Glyph selection: overflow dashes win, then leading-zero blanking from the top digit down.
  always_comb begin
    if (hex_r) begin
      ovf_s = |(val_ext_s >> (4 * DIGITS));
    end else begin
      ovf_s = |(bcd_ext_s >> (4 * DIGITS));
    end
    lead_s = 1'b1;
    nib_s  = 4'd0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      if (hex_r) begin
        nib_s = val_ext_s[4*d +: 4];
      end else begin
        nib_s = bcd_ext_s[4*d +: 4];
      end
      lead_s = lead_s && (nib_s == 4'd0);
      if (ovf_s) begin
        glyph_s[d] = GLYPH_DASH;
      end else if ((BLANK_LZ != 0) && lead_s && (d > 0)) begin
        glyph_s[d] = GLYPH_BLANK;
      end else begin
        glyph_s[d] = glyph(nib_s);
      end
    end
  end

  // Display register: only COMMIT changes it, so the old value stays lit during conversion.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int d = 0; d < DIGITS; d++) begin
        disp_glyph_r[d] <= ((d == 0) || (BLANK_LZ == 0)) ? glyph(4'h0) : GLYPH_BLANK;
      end
      disp_dp_r <= '0;
    end else if (state_r == COMMIT) begin
      for (int d = 0; d < DIGITS; d++) begin
        disp_glyph_r[d] <= glyph_s[d];
      end
      disp_dp_r <= dpm_r;
    end
  end

  // Refresh counter and digit index, free-running regardless of conversion.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= '0;
      idx_r <= '0;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= '0;
      idx_r <= (idx_r == IDX_LAST) ? '0 : idx_r + IDX_W'(1);
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Pin register: anode, segments and DP all switch on the same edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      an_r     <= '1;
      seg_r    <= GLYPH_BLANK;
      dp_pin_r <= 1'b1;
    end else begin
      an_r     <= ~(DIGITS'(1) << idx_r);
      seg_r    <= disp_glyph_r[idx_r];
      dp_pin_r <= ~disp_dp_r[idx_r];
    end
  end

  assign busy = busy_r;
  assign {CA, CB, CC, CD, CE, CF, CG} = seg_r;
  assign DP = dp_pin_r;
  assign AN = an_r;

endmodule

// File: tb/tb_sev_seg_scanner.sv
// Directed and randomized bench for sev_seg_scanner with an arithmetic
// reference model of what each digit should show.
module tb_sev_seg_scanner;

  localparam int DIGITS      = 4;
  localparam int VALUE_W     = 32;
  localparam int REFRESH_DIV = 4;

  logic        clock    = 1'b0;
  logic        reset_n  = 1'b0;
  logic [31:0] value    = 32'd0;
  logic        load     = 1'b0;
  logic        hex_mode = 1'b0;
  logic [3:0]  dp_mask  = 4'd0;
  logic        busy;
  logic        CA, CB, CC, CD, CE, CF, CG, DP;
  logic [3:0]  AN;

  int tests = 0;
  int fails = 0;

  logic [6:0] seg_tab [16];
  logic [6:0] cur_seg [4];
  logic [3:0] cur_dp;

  always #5 clock = ~clock;

  sev_seg_scanner #(
    .DIGITS      (DIGITS),
    .VALUE_W     (VALUE_W),
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_LZ    (1)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .value    (value),
    .load     (load),
    .hex_mode (hex_mode),
    .dp_mask  (dp_mask),
    .busy     (busy),
    .CA       (CA),
    .CB       (CB),
    .CC       (CC),
    .CD       (CD),
    .CE       (CE),
    .CF       (CF),
    .CG       (CG),
    .DP       (DP),
    .AN       (AN)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] pins();
    return {AN, CA, CB, CC, CD, CE, CF, CG, DP};
  endfunction

  function automatic logic [11:0] exp_pins(input int d);
    logic [3:0] an;
    an = ~(4'b0001 << d);
    return {an, cur_seg[d], ~cur_dp[d]};
  endfunction

  function automatic int an_digit();
    for (int d = 0; d < 4; d++) begin
      if (AN[d] == 1'b0) return d;
    end
    return 0;
  endfunction

  // What the display should show for a value, computed with plain arithmetic.
  task automatic model(input logic [31:0] v, input logic hx, input logic [3:0] dpm);
    longint unsigned vv;
    longint unsigned p;
    int  n [4];
    bit  ovf;
    bit  lead;
    vv = v;
    p  = 1;
    for (int d = 0; d < 4; d++) begin
      if (hx) n[d] = int'((vv >> (4 * d)) & 64'd15);
      else    n[d] = int'((vv / p) % 64'd10);
      p = p * 10;
    end
    ovf  = hx ? ((vv >> 16) != 0) : (vv >= 10000);
    lead = 1'b1;
    for (int d = 3; d >= 0; d--) begin
      if (n[d] != 0) lead = 1'b0;
      if (ovf)                    cur_seg[d] = 7'b111_1110;
      else if (lead && (d > 0))   cur_seg[d] = 7'h7F;
      else                        cur_seg[d] = seg_tab[n[d]];
    end
    cur_dp = dpm;
  endtask

  // Align to the start of a scan frame and check all DIGITS*REFRESH_DIV cycles.
  task automatic check_frame(input string tag);
    logic [3:0] prev;
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      prev = AN;
      @(negedge clock);
      if (AN == 4'b1110 && prev != 4'b1110) found = 1'b1;
    end
    chk({tag, "_sync"}, 32'(found), 32'd1);
    if (found) begin
      for (int k = 0; k < DIGITS * REFRESH_DIV; k++) begin
        if (k > 0) @(negedge clock);
        chk({tag, "_frame"}, 32'(pins()), 32'(exp_pins(k / REFRESH_DIV)));
      end
    end
  endtask

  // Load a value, optionally fire a second load at busy sample inj_at, check
  // busy length, old display held during conversion, then the new display.
  task automatic do_load(input logic [31:0] v, input logic hx, input logic [3:0] dpm,
                         input int inj_at, input string tag);
    int cnt;
    bit done;
    cnt  = 0;
    done = 1'b0;
    @(negedge clock);
    value = v; hex_mode = hx; dp_mask = dpm; load = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clock);
      load = 1'b0;
      if (busy) begin
        cnt++;
        chk({tag, "_old"}, 32'(pins()), 32'(exp_pins(an_digit())));
        if (cnt - 1 == inj_at) begin
          value = v ^ 32'h0000_0005; hex_mode = 1'b0; dp_mask = ~dpm; load = 1'b1;
        end
      end else begin
        done = 1'b1;
      end
    end
    chk({tag, "_busy_len"}, 32'(cnt), hx ? 32'd1 : 32'd33);
    chk({tag, "_hold"}, 32'(pins()), 32'(exp_pins(an_digit())));
    model(v, hx, dpm);
    @(negedge clock);
    chk({tag, "_new"}, 32'(pins()), 32'(exp_pins(an_digit())));
    check_frame(tag);
  endtask

  initial begin
    logic [31:0] rv;
    logic        rh;
    seg_tab = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    // Reset held: outputs idle.
    repeat (3) @(negedge clock);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pins", 32'(pins()), 32'hFFF);
    reset_n = 1'b1;
    model(32'd0, 1'b0, 4'b0000);
    @(negedge clock);
    chk("first_digit", 32'(AN), 32'hE);
    chk("first_seg", 32'(pins()), 32'(exp_pins(0)));
    check_frame("reset");

    // Directed cases.
    do_load(32'd1234, 1'b0, 4'b0100, -1, "dec1234");
    do_load(32'd7, 1'b0, 4'b0000, -1, "dec7");
    do_load(32'd10000, 1'b0, 4'b1001, -1, "dec_ovf");
    do_load(32'd9999, 1'b0, 4'b0000, -1, "dec9999");
    do_load(32'h0000_BEEF, 1'b1, 4'b0000, -1, "hexbeef");
    do_load(32'h0001_0000, 1'b1, 4'b0010, -1, "hex_ovf");
    do_load(32'd0, 1'b1, 4'b1111, -1, "hex0");
    do_load(32'd1234, 1'b0, 4'b0000, 5, "inj_shift");
    do_load(32'd5678, 1'b0, 4'b0001, 32, "inj_edge");

    // Reset pulsed in the middle of a conversion.
    @(negedge clock);
    value = 32'd4321; hex_mode = 1'b0; dp_mask = 4'b0000; load = 1'b1;
    @(negedge clock);
    load = 1'b0;
    repeat (9) @(negedge clock);
    chk("abort_pre_busy", 32'(busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_pins", 32'(pins()), 32'hFFF);
    @(negedge clock);
    reset_n = 1'b1;
    model(32'd0, 1'b0, 4'b0000);
    check_frame("post_abort");
    do_load(32'd42, 1'b0, 4'b0001, -1, "fresh");

    // Randomized loads.
    for (int r = 0; r < 8; r++) begin
      rh = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       rv = 32'($urandom_range(0, 99));
        1:       rv = rh ? 32'($urandom_range(0, 65535)) : 32'($urandom_range(0, 9999));
        2:       rv = $urandom;
        default: rv = rh ? 32'h0000_FFFF : 32'd9999;
      endcase
      do_load(rv, rh, 4'($urandom_range(0, 15)), -1, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
